dmem_master: RTL

DMEM_MASTER -- requirements
Module: dmem_master

---
 rtl/dmem_master_pkg.sv | 33 +++
 rtl/data_memory.sv | 26 ++
 rtl/dmem_lane.sv | 60 ++++++
 rtl/head.sv | 22 ++
 rtl/dmem_master.sv | 115 +++++++++++
 5 files changed

// File: rtl/dmem_master_pkg.sv
// Typed views of the shared opcode and state encodings used by the
// data-memory master and its lane logic.
`ifndef DMEM_HEAD_V
`include "head.sv"
`endif

package dmem_master_pkg;

    localparam int AW = `DATA_MEM_ADDRESS;

    typedef enum logic [2:0] {
        OP_LW  = `DMEM_OP_LW,
        OP_LH  = `DMEM_OP_LH,
        OP_LHU = `DMEM_OP_LHU,
        OP_LB  = `DMEM_OP_LB,
        OP_LBU = `DMEM_OP_LBU,
        OP_SW  = `DMEM_OP_SW,
        OP_SH  = `DMEM_OP_SH,
        OP_SB  = `DMEM_OP_SB
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = `DMEM_ST_IDLE,
        ST_READ  = `DMEM_ST_READ,
        ST_WRITE = `DMEM_ST_WRITE,
        ST_RESP  = `DMEM_ST_RESP
    } state_e;

    function automatic logic is_store(op_e op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: combinational read, write on the clock edge
// when dm_wen is high.
`ifndef DMEM_HEAD_V
`include "head.sv"
`endif

module data_memory (
    input  logic                         clk,
    input  logic                         dm_wen,
    input  logic [`DATA_MEM_ADDRESS-1:0] dm_address,
    input  logic [31:0]                  dm_write_data,
    output logic [31:0]                  dm_read_data
);

    logic [31:0] mem [0:(1 << `DATA_MEM_ADDRESS) - 1];

    // NOTE: the storage array has no reset; clearing a RAM costs a port per word and software initialises it anyway.
    always_ff @(posedge clk) begin
        if (dm_wen) begin
            mem[dm_address] <= dm_write_data;
        end
    end

    assign dm_read_data = mem[dm_address];

endmodule

// File: rtl/dmem_lane.sv
// Combinational byte-lane logic: load extraction/extension, store merge
// into a previously read word, and alignment checking of a new request.
`ifndef DMEM_HEAD_V
`include "head.sv"
`endif

module dmem_lane
    import dmem_master_pkg::*;
(
    input  logic [2:0]  chk_op,
    input  logic [1:0]  chk_addr,
    output logic        misaligned,
    input  logic [2:0]  op,
    input  logic [1:0]  addr,
    input  logic [31:0] rd_word,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = rd_word[{addr, 3'b000} +: 8];
    assign ld_half = rd_word[{addr[1], 4'b0000} +: 16];

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves a latch behind.
        ld_data = rd_word;
        case (op_e'(op))
            OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data = {24'h0, ld_byte};
            OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data = {16'h0, ld_half};
            default: ld_data = rd_word;
        endcase
    end

    // Sub-word stores replace only the addressed lane(s) of the word read earlier.
    always_comb begin
        st_word = old_word;
        case (op_e'(op))
            OP_SW:   st_word = wdata;
            OP_SH:   st_word[{addr[1], 4'b0000} +: 16] = wdata[15:0];
            OP_SB:   st_word[{addr, 3'b000} +: 8] = wdata[7:0];
            default: st_word = old_word;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (op_e'(chk_op))
            OP_LW, OP_SW:        misaligned = |chk_addr;
            OP_LH, OP_LHU, OP_SH: misaligned = chk_addr[0];
            default:             misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/head.sv
// Shared definitions for the data-memory path: memory geometry, request
// opcodes and dmem_master state codes.
`ifndef DMEM_HEAD_V
`define DMEM_HEAD_V

`define DATA_MEM_ADDRESS 8

`define DMEM_OP_LW  3'd0
`define DMEM_OP_LH  3'd1
`define DMEM_OP_LHU 3'd2
`define DMEM_OP_LB  3'd3
`define DMEM_OP_LBU 3'd4
`define DMEM_OP_SW  3'd5
`define DMEM_OP_SH  3'd6
`define DMEM_OP_SB  3'd7

`define DMEM_ST_IDLE  2'd0
`define DMEM_ST_READ  2'd1
`define DMEM_ST_WRITE 2'd2
`define DMEM_ST_RESP  2'd3

`endif

// File: rtl/dmem_master.sv
// Data-memory master: turns one pipeline load/store into memory cycles,
// using read-modify-write for sub-word stores, then a one-cycle response.
`ifndef DMEM_HEAD_V
`include "head.sv"
`endif

module dmem_master
    import dmem_master_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [2:0]                   req_op,
    input  logic [31:0]                  req_addr,
    input  logic [31:0]                  req_wdata,
    output logic                         resp_valid,
    output logic [31:0]                  resp_rdata,
    output logic                         resp_err,
    output logic                         dm_wen,
    output logic [`DATA_MEM_ADDRESS-1:0] dm_address,
    output logic [31:0]                  dm_write_data,
    input  logic [31:0]                  dm_read_data
);

    state_e        state;
    op_e           op_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   word_q;

    logic          accept;
    logic          misaligned;
    logic [31:0]   ld_data;
    logic [31:0]   st_word;
    logic          unused_addr_hi;

    // Address bits above the memory size are dropped so accesses wrap.
    assign unused_addr_hi = ^req_addr[31:AW+2];

    assign accept        = req_valid && req_ready;
    assign req_ready     = (state == ST_IDLE);
    assign dm_wen        = (state == ST_WRITE);
    assign dm_address    = addr_q[AW+1:2];
    assign dm_write_data = st_word;

    dmem_lane u_lane (
        .chk_op     (req_op),
        .chk_addr   (req_addr[1:0]),
        .misaligned (misaligned),
        .op         (op_q),
        .addr       (addr_q[1:0]),
        .rd_word    (dm_read_data),
        .old_word   (word_q),
        .wdata      (wdata_q),
        .ld_data    (ld_data),
        .st_word    (st_word)
    );

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_q       <= OP_LW;
            addr_q     <= '0;
            wdata_q    <= '0;
            word_q     <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= op_e'(req_op);
                        addr_q  <= req_addr[AW+1:0];
                        wdata_q <= req_wdata;
                        if (misaligned) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (op_e'(req_op) == OP_SW) begin
                            state <= ST_WRITE;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    word_q <= dm_read_data;
                    if (is_store(op_q)) begin
                        state <= ST_WRITE;
                    end else begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= ld_data;
                    end
                end
                ST_WRITE: begin
                    state      <= ST_RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
